// File: rtl/fifo.sv
// Single-clock FIFO with registered read data and a busy flag for the producer.
// Memory contents are not reset; only pointers, occupancy and rd_data are cleared.
module fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_e,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_e,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_rd_data;

    logic w_empty;
    logic w_full;
    logic w_rd_ok;
    logic w_wr_ok;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_rd_ok = rd_e && !w_empty;
    // A read in the same cycle frees a slot, so a full FIFO can still accept the write.
    assign w_wr_ok = wr_e && (!w_full || w_rd_ok);

    always_ff @(posedge clk) begin
        if (w_wr_ok && rst) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rptr    <= r_rptr + AW'(1);
                r_rd_data <= r_mem[r_rptr];
            end
            if (w_wr_ok && !w_rd_ok) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_rd_ok && !w_wr_ok) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    assign rd_data = r_rd_data;
    assign busy    = w_full || !rst;

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_fifo;

    localparam int WIDTH = 2;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_e = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_e = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    int m_q[$];
    int m_rd = 0;

    fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_e    (wr_e),
        .wr_data (wr_data),
        .rd_e    (rd_e),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare just after the edge.
    task automatic cyc(input bit r, input bit w, input int d, input bit rd);
        bit rd_ok;
        bit wr_ok;
        rst     = r;
        wr_e    = w;
        wr_data = d[WIDTH-1:0];
        rd_e    = rd;
        @(posedge clk);
        #1;
        if (!r) begin
            m_q.delete();
            m_rd = 0;
        end else begin
            rd_ok = rd && (m_q.size() > 0);
            wr_ok = w && ((m_q.size() < DEPTH) || rd_ok);
            if (rd_ok) m_rd = m_q.pop_front();
            if (wr_ok) m_q.push_back(d % (1 << WIDTH));
        end
        chk("rd_data", int'(rd_data), m_rd);
        chk("busy", int'(busy), ((m_q.size() == DEPTH) || !r) ? 1 : 0);
    endtask

    initial begin
        #1;
        // Reset hold for two edges, then release.
        cyc(0, 1, 3, 1);
        cyc(0, 0, 0, 0);
        chk("reset_rd_data", int'(rd_data), 0);
        chk("reset_busy", int'(busy), 1);
        cyc(1, 0, 0, 0);
        chk("release_busy", int'(busy), 0);

        // Single write, idle, single read.
        cyc(1, 1, 2, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        chk("single_read", int'(rd_data), 2);
        cyc(1, 0, 0, 0);
        chk("single_hold", int'(rd_data), 2);

        // Fill, overflow, drain.
        for (int i = 0; i < 8; i++) cyc(1, 1, i % 4, 0);
        chk("full_busy", int'(busy), 1);
        cyc(1, 1, 3, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 1);
            chk("drain_order", int'(rd_data), i % 4);
            if (i == 0) chk("busy_after_first_read", int'(busy), 0);
        end

        // Underflow with rd_data = 1.
        cyc(1, 1, 1, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        chk("underflow_hold", int'(rd_data), 1);
        cyc(1, 1, 2, 0);
        cyc(1, 0, 0, 1);
        chk("after_underflow", int'(rd_data), 2);

        // Simultaneous access while full, then while empty.
        for (int i = 0; i < 8; i++) cyc(1, 1, i % 3, 0);
        cyc(1, 1, 3, 1);
        chk("full_rw_oldest", int'(rd_data), 0);
        chk("full_rw_busy", int'(busy), 1);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1);
        chk("full_rw_last", int'(rd_data), 3);
        cyc(1, 1, 1, 1);
        chk("empty_rw_hold", int'(rd_data), 3);
        cyc(1, 0, 0, 1);
        chk("empty_rw_written", int'(rd_data), 1);

        // Wrap-around at occupancy 3.
        for (int i = 0; i < 3; i++) cyc(1, 1, i, 0);
        for (int i = 0; i < 20; i++) cyc(1, 1, $urandom_range(0, 3), 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);

        // Mid-operation reset at occupancy 5.
        for (int i = 0; i < 5; i++) cyc(1, 1, 3, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 1);
        chk("post_reset_read", int'(rd_data), 0);
        chk("post_reset_busy", int'(busy), 0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0),
                $urandom_range(0, 3), ($urandom_range(0, 2) == 0 || i > 2000));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
